imem_loader: RTL and testbench

//  Write-side counterpart of the instruction fetch path: takes a byte stream over a

---
 rtl/mips_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the instruction memory path.
// Loader state encoding and memory geometry.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes into one little-endian word.
// Emits the word combinationally with the 4th byte.
import mips_pkg::*;

module byte_packer (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (accept) begin
      lane  <= lane + 2'd1;
      shreg <= {data, shreg[23:8]};
    end
  end

  assign word_valid = accept && (lane == 2'd3);
  assign word       = {data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream image loader for imem with length/checksum framing.
// Holds the core until a clean image has been written.
import mips_pkg::*;

module imem_loader #(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT);

  ld_state_t         state, state_n;
  logic [ADDR_W:0]   len_q, word_idx;
  logic [7:0]        sum;
  logic [TW-1:0]     timer;
  logic              accept, data_acc, enter_len;
  logic              tmo, len_ok, last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = rx_valid && rx_ready;
  assign data_acc  = accept && (state == LD_DATA);
  assign tmo       = (timer == TW'(TIMEOUT - 1));
  assign len_ok    = (rx_data != 8'd0) &&
                     (32'(rx_data) <= 32'(1 << ADDR_W));
  assign last_word = (word_idx == len_q - 1'b1);
  assign enter_len = (state_n == LD_LEN) && (state != LD_LEN);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (enter_len),
    .accept     (data_acc),
    .data       (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      LD_IDLE: if (start) state_n = LD_LEN;
      LD_LEN: begin
        if (accept)   state_n = len_ok ? LD_DATA : LD_ERR;
        else if (tmo) state_n = LD_ERR;
      end
      LD_DATA: begin
        if (word_valid && last_word) state_n = LD_CSUM;
        else if (!accept && tmo)     state_n = LD_ERR;
      end
      LD_CSUM: begin
        if (accept)
          state_n = (8'(sum + rx_data) == 8'd0) ? LD_DONE : LD_ERR;
        else if (tmo)
          state_n = LD_ERR;
      end
      LD_DONE, LD_ERR: if (start) state_n = LD_LEN;
      default: state_n = LD_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they move with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LD_IDLE;
      rx_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      rx_ready <= (state_n == LD_LEN) || (state_n == LD_DATA) ||
                  (state_n == LD_CSUM);
      cpu_hold <= (state_n != LD_DONE);
      done     <= (state_n == LD_DONE);
      err      <= (state_n == LD_ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      word_idx <= '0;
      sum      <= '0;
      timer    <= '0;
    end else begin
      if (state == LD_LEN && accept)
        len_q <= rx_data[ADDR_W:0];
      if (enter_len)
        word_idx <= '0;
      else if (word_valid)
        word_idx <= word_idx + 1'b1;
      if (enter_len)
        sum <= '0;
      else if (data_acc)
        sum <= sum + rx_data;
      if (enter_len || accept)
        timer <= '0;
      else if (rx_ready)
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= word_valid;
      if (word_valid) begin
        waddr <= word_idx[ADDR_W-1:0];
        wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Frames are built and judged by a byte-level reference model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready, we, cpu_hold, done, err;
  logic [5:0] waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_errors = 0;
  int stalls = 0;
  logic [37:0] wq[$];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) wq.push_back({waddr, wdata});

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    bit rdy;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      @(negedge clk);
      rdy = rx_ready;
      if (!rdy) stalls++;
      @(posedge clk);
      budget++;
    end while (!rdy && budget < 2000);
    #1;
    rx_valid = 1'b0;
    if (!rdy) check("accept_budget", 32'd0, 32'd1);
  endtask

  // Reference: frame is legal iff 1<=n<=64; image clean iff bytes+csum == 0 mod 256.
  task automatic run_frame(input int n, input logic [7:0] d[$],
                           input logic [7:0] csum, input int gap_max,
                           input bit do_start);
    int s = 0;
    bit good;
    logic [31:0] w;
    if (do_start) pulse_start();
    wq.delete();
    send_byte(8'(n));
    if (n < 1 || n > 64) begin
      check("len_err", {31'd0, err}, 32'd1);
      check("len_done", {31'd0, done}, 32'd0);
      idle(2);
      check("len_nowrite", wq.size(), 32'd0);
      return;
    end
    foreach (d[i]) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_byte(d[i]);
      s += d[i];
    end
    send_byte(csum);
    good = ((s + csum) % 256) == 0;
    check("done", {31'd0, done}, {31'd0, good});
    check("err", {31'd0, err}, {31'd0, !good});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !good});
    check("rdy_after", {31'd0, rx_ready}, 32'd0);
    idle(1);
    check("wr_count", wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++) begin
      w = d[4*k] + (d[4*k+1] << 8) + (d[4*k+2] << 16) + (d[4*k+3] << 24);
      check("wr_addr", {26'd0, wq[k][37:32]}, k);
      check("wr_data", wq[k][31:0], w);
    end
  endtask

  task automatic make_bytes(input int n, output logic [7:0] d[$],
                            output logic [7:0] good_csum);
    int s = 0;
    d.delete();
    for (int i = 0; i < 4 * n; i++) begin
      d.push_back(8'($urandom));
      s += d[i];
    end
    good_csum = 8'(256 - (s % 256));
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] cs;
    int n;

    #2 rst = 1'b1;
    idle(2);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {26'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    idle(1);

    // start with a byte already offered: byte must not be taken in IDLE
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'd2;
    @(negedge clk);
    check("idle_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    d = '{8'h20, 8'h00, 8'h43, 8'h00, 8'h22, 8'h18, 8'h64, 8'h00};
    run_frame(2, d, 8'h49, 0, 1'b0);
    if (wq.size() == 2) begin
      check("dir_w0", wq[0][31:0], 32'h00430020);
      check("dir_w1", wq[1][31:0], 32'h00641822);
    end else check("dir_count", wq.size(), 32'd2);

    run_frame(2, d, 8'h48, 0, 1'b1);
    d.delete();
    run_frame(0, d, 8'h00, 0, 1'b1);
    run_frame(65, d, 8'h00, 0, 1'b1);

    // stall after second data byte
    pulse_start();
    send_byte(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (1023) @(posedge clk);
    #1;
    check("tmo_early", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    check("tmo_ready", {31'd0, rx_ready}, 32'd0);
    make_bytes(1, d, cs);
    run_frame(1, d, cs, 0, 1'b1);

    // full-depth image, bytes back-to-back
    make_bytes(64, d, cs);
    pulse_start();
    stalls = 0;
    run_frame(64, d, cs, 0, 1'b0);
    check("b2b_stalls", stalls, 32'd0);

    // reset in the middle of word 3 of 5, with an ignored start
    make_bytes(5, d, cs);
    pulse_start();
    wq.delete();
    send_byte(8'd5);
    for (int i = 0; i < 9; i++) begin
      start = (i == 8);
      send_byte(d[i]);
    end
    start = 1'b0;
    send_byte(d[9]);
    rst = 1'b1;
    #1;
    check("mid_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_count", wq.size(), 32'd2);
    for (int k = 0; k < 2 && k < wq.size(); k++)
      check("mid_addr", {26'd0, wq[k][37:32]}, k);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 255);
      else n = $urandom_range(1, 8);
      if (n >= 1 && n <= 64) make_bytes(n, d, cs);
      else d.delete();
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_frame(n, d, cs, $urandom_range(0, 4), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
